approx_mult_error_monitor: RTL and testbench
============================================

Name: approx_mult_error_monitor

Overview:
- Downstream consumer of the 8-bit approximate multiplier: samples each operand pair together with the multiplier's 17-bit product.
- Computes the exact product internally and accumulates error statistics over a fixed-length run: error count, error-distance sum, and maximum error distance with its operands.
- Used in characterization runs (exhaustive 256x256 sweeps) and in silicon self-check; results are held stable for readout once the run completes.

Parameters:
- SAMPLES, 65536, number of accepted samples per run (1..65536).
- SUM_W, 40, width of the error-distance accumulator.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse: clear stats, begin run (honoured in IDLE/DONE only).
- in_valid  input  1  sample present on in1/in2/approx_out.
- in_ready  output  1  monitor accepts sample this cycle.
- in1  input  8  multiplicand fed to the multiplier.
- in2  input  8  multiplier operand fed to the multiplier.
- approx_out  input  17  multiplier product for in1,in2.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE; stats valid.
- sample_cnt  output  17  samples accepted this run.
- err_cnt  output  17  samples with approx_out != exact.
- sum_ed  output  SUM_W  sum of |approx_out - exact|, saturating.
- max_ed  output  17  largest error distance seen.
- max_in1  output  8  in1 of the max_ed sample.
- max_in2  output  8  in2 of the max_ed sample.

Behaviour:
- Reset (rst=1 at a clock edge, any state incl. mid-run): state IDLE; in_ready, busy, done = 0; all counters, sum_ed, max_ed, max_in1, max_in2 = 0; pipeline valid bits cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE --start--> RUN: same edge clears all stats and pipeline.
- RUN: in_ready=1. Accept = in_valid && in_ready; sample_cnt increments on accept. When the accept that makes sample_cnt == SAMPLES occurs -> DRAIN (in_ready=0 from next cycle).
- DRAIN: in_ready=0; remain until both pipeline stages empty, then -> DONE.
- DONE: done=1, stats frozen; start -> RUN (clear as above). start in RUN/DRAIN ignored.
- Pipeline, 2 stages:
  - S1 registers in1, in2, approx_out and exact = in1*in2 (16 bit, zero-extended to 17).
  - S2 computes ed = |approx_out - exact| (17 bits, unsigned, no overflow) and updates stats.
  - A sample affects err_cnt/sum_ed/max_ed exactly 2 cycles after acceptance; done rises the cycle after the last S2 update (3 cycles after the final accept).
- err_cnt increments when ed != 0.
- sum_ed += ed; saturates at 2^SUM_W-1, never wraps.
- max update only when ed > max_ed (strict); ties keep the first-occurring operands.
- Gaps (in_valid=0) in RUN: no accept, no counter change; pipeline bubbles carry no update.
- Inputs are ignored whenever in_ready=0, including in_valid=1 in IDLE/DRAIN/DONE.
- sample_cnt saturates at SAMPLES; 17 bits hold 65536.

Test Plan:
- Exhaustive exact: SAMPLES=65536, all pairs with approx_out = in1*in2, in_valid held 1 -> err_cnt=0, sum_ed=0, max_ed=0, sample_cnt=65536, done 3 cycles after final accept.
- Over/under error: SAMPLES=3; samples (122,122,14889), (255,255,0), (3,4,12) -> err_cnt=2, sum_ed=5+65025=65030, max_ed=65025, max_in1=255, max_in2=255.
- Tie ordering: SAMPLES=2; (2,3,10) then (1,4,8) (both ed=4) -> max_ed=4, max_in1=2, max_in2=3.
- Bubbles and ignored input: SAMPLES=4, in_valid toggled 1,0,1,0,...; in_valid=1 asserted in IDLE before start and in DONE -> exactly 4 accepts; no stats change outside RUN.
- Saturation: SUM_W=17, SAMPLES=4, four samples with ed=65025 -> sum_ed=131071, err_cnt=4.
- Reset mid-run: rst after 10 accepts in RUN -> next cycle IDLE, all outputs 0; subsequent start/run of SAMPLES=2 with (122,122,14884),(1,1,2) -> err_cnt=1, sum_ed=1.

Source files
------------

// File: rtl/approx_mult_error_monitor.sv
// Error-statistics monitor for the 8-bit approximate multiplier.
// Compares each accepted product against the exact one and accumulates run statistics.
module approx_mult_error_monitor #(
  parameter int unsigned SAMPLES = 65536,
  parameter int unsigned SUM_W   = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in1,
  input  logic [7:0]       in2,
  input  logic [16:0]      approx_out,
  output logic             busy,
  output logic             done,
  output logic [16:0]      sample_cnt,
  output logic [16:0]      err_cnt,
  output logic [SUM_W-1:0] sum_ed,
  output logic [16:0]      max_ed,
  output logic [7:0]       max_in1,
  output logic [7:0]       max_in2
);

  localparam int unsigned CNT_W  = 17;
  localparam int unsigned SUM_XW = SUM_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES - 1);
  localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(SAMPLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic              w_in_ready, w_busy, w_done;
  logic              w_accept, w_start_ok;
  logic              r_s1_valid;
  logic [7:0]        r_s1_in1, r_s1_in2;
  logic [16:0]       r_s1_approx, r_s1_exact;
  logic [15:0]       w_prod;
  logic [16:0]       w_ed;
  logic [SUM_W:0]    w_sum_ext;
  logic [CNT_W-1:0]  r_sample_cnt, r_err_cnt;
  logic [SUM_W-1:0]  r_sum_ed;
  logic [16:0]       r_max_ed;
  logic [7:0]        r_max_in1, r_max_in2;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && (r_sample_cnt == LAST_CNT)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_s1_valid) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_RUN:   begin w_in_ready = 1'b1; w_busy = 1'b1; end
      S_DRAIN: w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  assign w_accept   = in_valid && w_in_ready;
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_prod     = 16'(in1) * 16'(in2);

  // Stage-2 error distance and saturating accumulation
  assign w_ed      = (r_s1_approx >= r_s1_exact) ? (r_s1_approx - r_s1_exact)
                                                 : (r_s1_exact - r_s1_approx);
  assign w_sum_ext = {1'b0, r_sum_ed} + SUM_XW'(w_ed);

  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_s1_valid   <= 1'b0;
      r_s1_in1     <= '0;
      r_s1_in2     <= '0;
      r_s1_approx  <= '0;
      r_s1_exact   <= '0;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_sum_ed     <= '0;
      r_max_ed     <= '0;
      r_max_in1    <= '0;
      r_max_in2    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_in1    <= in1;
        r_s1_in2    <= in2;
        r_s1_approx <= approx_out;
        r_s1_exact  <= {1'b0, w_prod};
        if (r_sample_cnt != SAT_CNT) r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      end
      if (r_s1_valid) begin
        if (w_ed != '0) r_err_cnt <= r_err_cnt + CNT_W'(1);
        r_sum_ed <= w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
        // Strictly greater keeps the first sample on ties
        if (w_ed > r_max_ed) begin
          r_max_ed  <= w_ed;
          r_max_in1 <= r_s1_in1;
          r_max_in2 <= r_s1_in2;
        end
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign busy       = w_busy;
  assign done       = w_done;
  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;
  assign sum_ed     = r_sum_ed;
  assign max_ed     = r_max_ed;
  assign max_in1    = r_max_in1;
  assign max_in2    = r_max_in2;

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Directed bench for approx_mult_error_monitor: four instances with different run lengths
// share the sample bus; each is started individually.
module tb_approx_mult_error_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in1, in2;
  logic [16:0] approx_out;
  logic        st_big, st3, st2, st4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic        big_rdy, big_busy, big_done;
  logic [16:0] big_cnt, big_err, big_max;
  logic [39:0] big_sum;
  logic [7:0]  big_m1, big_m2;

  logic        s3_rdy, s3_busy, s3_done;
  logic [16:0] s3_cnt, s3_err, s3_max;
  logic [39:0] s3_sum;
  logic [7:0]  s3_m1, s3_m2;

  logic        s2_rdy, s2_busy, s2_done;
  logic [16:0] s2_cnt, s2_err, s2_max;
  logic [39:0] s2_sum;
  logic [7:0]  s2_m1, s2_m2;

  logic        s4_rdy, s4_busy, s4_done;
  logic [16:0] s4_cnt, s4_err, s4_max;
  logic [16:0] s4_sum;
  logic [7:0]  s4_m1, s4_m2;

  approx_mult_error_monitor #(.SAMPLES(65536), .SUM_W(40)) u_big (
    .clk(clk), .rst(rst), .start(st_big), .in_valid(in_valid), .in_ready(big_rdy),
    .in1(in1), .in2(in2), .approx_out(approx_out), .busy(big_busy), .done(big_done),
    .sample_cnt(big_cnt), .err_cnt(big_err), .sum_ed(big_sum), .max_ed(big_max),
    .max_in1(big_m1), .max_in2(big_m2));

  approx_mult_error_monitor #(.SAMPLES(3), .SUM_W(40)) u_s3 (
    .clk(clk), .rst(rst), .start(st3), .in_valid(in_valid), .in_ready(s3_rdy),
    .in1(in1), .in2(in2), .approx_out(approx_out), .busy(s3_busy), .done(s3_done),
    .sample_cnt(s3_cnt), .err_cnt(s3_err), .sum_ed(s3_sum), .max_ed(s3_max),
    .max_in1(s3_m1), .max_in2(s3_m2));

  approx_mult_error_monitor #(.SAMPLES(2), .SUM_W(40)) u_s2 (
    .clk(clk), .rst(rst), .start(st2), .in_valid(in_valid), .in_ready(s2_rdy),
    .in1(in1), .in2(in2), .approx_out(approx_out), .busy(s2_busy), .done(s2_done),
    .sample_cnt(s2_cnt), .err_cnt(s2_err), .sum_ed(s2_sum), .max_ed(s2_max),
    .max_in1(s2_m1), .max_in2(s2_m2));

  approx_mult_error_monitor #(.SAMPLES(4), .SUM_W(17)) u_s4 (
    .clk(clk), .rst(rst), .start(st4), .in_valid(in_valid), .in_ready(s4_rdy),
    .in1(in1), .in2(in2), .approx_out(approx_out), .busy(s4_busy), .done(s4_done),
    .sample_cnt(s4_cnt), .err_cnt(s4_err), .sum_ed(s4_sum), .max_ed(s4_max),
    .max_in1(s4_m1), .max_in2(s4_m2));

  // Drive one cycle of bus values, then return 1 time unit after the next rising edge
  task automatic cyc(input logic v, input logic [7:0] a, input logic [7:0] b,
                     input logic [16:0] p);
    in_valid   = v;
    in1        = a;
    in2        = b;
    approx_out = p;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    rst = 1'b0;
    checks++;
    if ({big_rdy, big_busy, big_done, big_cnt, big_err, big_sum, big_max, big_m1, big_m2} !== '0) begin
      failures++;
      $display("FAIL reset_big got rdy=%b busy=%b done=%b cnt=%0d err=%0d sum=%0d max=%0d exp all 0",
               big_rdy, big_busy, big_done, big_cnt, big_err, big_sum, big_max);
    end
    checks++;
    if ({s3_rdy, s3_busy, s3_done, s2_done, s4_done, s4_sum} !== '0) begin
      failures++;
      $display("FAIL reset_small got s3_rdy=%b s3_busy=%b s3_done=%b s2_done=%b s4_done=%b s4_sum=%0d exp 0",
               s3_rdy, s3_busy, s3_done, s2_done, s4_done, s4_sum);
    end
  endtask

  task automatic test_over_under;
    st3 = 1'b1;
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    st3 = 1'b0;
    cyc(1'b1, 8'd122, 8'd122, 17'd14889);
    cyc(1'b1, 8'd255, 8'd255, 17'd0);
    cyc(1'b1, 8'd3, 8'd4, 17'd12);
    checks++;
    if (s3_rdy !== 1'b0 || s3_busy !== 1'b1 || s3_done !== 1'b0) begin
      failures++;
      $display("FAIL ou_drain got rdy=%b busy=%b done=%b exp 0 1 0", s3_rdy, s3_busy, s3_done);
    end
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    checks++;
    if (s3_done !== 1'b0 || s3_err !== 17'd2) begin
      failures++;
      $display("FAIL ou_last_update got done=%b err=%0d exp 0 2", s3_done, s3_err);
    end
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    checks++;
    if (s3_done !== 1'b1 || s3_busy !== 1'b0) begin
      failures++;
      $display("FAIL ou_done got done=%b busy=%b exp 1 0", s3_done, s3_busy);
    end
    checks++;
    if (s3_cnt !== 17'd3 || s3_err !== 17'd2 || s3_sum !== 40'd65030) begin
      failures++;
      $display("FAIL ou_counts got cnt=%0d err=%0d sum=%0d exp 3 2 65030", s3_cnt, s3_err, s3_sum);
    end
    checks++;
    if (s3_max !== 17'd65025 || s3_m1 !== 8'd255 || s3_m2 !== 8'd255) begin
      failures++;
      $display("FAIL ou_max got max=%0d in1=%0d in2=%0d exp 65025 255 255", s3_max, s3_m1, s3_m2);
    end
  endtask

  task automatic test_tie;
    st2 = 1'b1;
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    st2 = 1'b0;
    cyc(1'b1, 8'd2, 8'd3, 17'd10);
    cyc(1'b1, 8'd1, 8'd4, 17'd8);
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    checks++;
    if (s2_done !== 1'b1 || s2_err !== 17'd2 || s2_sum !== 40'd8) begin
      failures++;
      $display("FAIL tie_counts got done=%b err=%0d sum=%0d exp 1 2 8", s2_done, s2_err, s2_sum);
    end
    checks++;
    if (s2_max !== 17'd4 || s2_m1 !== 8'd2 || s2_m2 !== 8'd3) begin
      failures++;
      $display("FAIL tie_max got max=%0d in1=%0d in2=%0d exp 4 2 3", s2_max, s2_m1, s2_m2);
    end
  endtask

  task automatic test_bubbles;
    cyc(1'b1, 8'd255, 8'd255, 17'd0);
    cyc(1'b1, 8'd255, 8'd255, 17'd0);
    checks++;
    if (s4_cnt !== 17'd0 || s4_rdy !== 1'b0 || s4_sum !== 17'd0) begin
      failures++;
      $display("FAIL bub_idle got cnt=%0d rdy=%b sum=%0d exp 0 0 0", s4_cnt, s4_rdy, s4_sum);
    end
    st4 = 1'b1;
    cyc(1'b1, 8'd255, 8'd255, 17'd0);
    st4 = 1'b0;
    checks++;
    if (s4_cnt !== 17'd0 || s4_busy !== 1'b1) begin
      failures++;
      $display("FAIL bub_start got cnt=%0d busy=%b exp 0 1", s4_cnt, s4_busy);
    end
    cyc(1'b1, 8'd10, 8'd10, 17'd100);
    cyc(1'b0, 8'd255, 8'd255, 17'd0);
    checks++;
    if (s4_cnt !== 17'd1) begin
      failures++;
      $display("FAIL bub_gap got cnt=%0d exp 1", s4_cnt);
    end
    cyc(1'b1, 8'd2, 8'd3, 17'd7);
    cyc(1'b0, 8'd255, 8'd255, 17'd0);
    cyc(1'b1, 8'd5, 8'd5, 17'd20);
    cyc(1'b0, 8'd255, 8'd255, 17'd0);
    cyc(1'b1, 8'd7, 8'd8, 17'd60);
    checks++;
    if (s4_cnt !== 17'd4 || s4_rdy !== 1'b0) begin
      failures++;
      $display("FAIL bub_last got cnt=%0d rdy=%b exp 4 0", s4_cnt, s4_rdy);
    end
    cyc(1'b1, 8'd255, 8'd255, 17'd0);
    cyc(1'b1, 8'd255, 8'd255, 17'd0);
    checks++;
    if (s4_done !== 1'b1) begin
      failures++;
      $display("FAIL bub_done got done=%b exp 1", s4_done);
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'd255, 8'd255, 17'd0);
    checks++;
    if (s4_cnt !== 17'd4 || s4_err !== 17'd3 || s4_sum !== 17'd10 || s4_done !== 1'b1) begin
      failures++;
      $display("FAIL bub_stats got cnt=%0d err=%0d sum=%0d done=%b exp 4 3 10 1",
               s4_cnt, s4_err, s4_sum, s4_done);
    end
    checks++;
    if (s4_max !== 17'd5 || s4_m1 !== 8'd5 || s4_m2 !== 8'd5) begin
      failures++;
      $display("FAIL bub_max got max=%0d in1=%0d in2=%0d exp 5 5 5", s4_max, s4_m1, s4_m2);
    end
  endtask

  task automatic test_saturation;
    st4 = 1'b1;
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    st4 = 1'b0;
    checks++;
    if (s4_cnt !== 17'd0 || s4_err !== 17'd0 || s4_sum !== 17'd0 || s4_max !== 17'd0 || s4_done !== 1'b0) begin
      failures++;
      $display("FAIL sat_clear got cnt=%0d err=%0d sum=%0d max=%0d done=%b exp 0 0 0 0 0",
               s4_cnt, s4_err, s4_sum, s4_max, s4_done);
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'd255, 8'd255, 17'd0);
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    checks++;
    if (s4_done !== 1'b1 || s4_sum !== 17'd131071 || s4_err !== 17'd4 || s4_max !== 17'd65025) begin
      failures++;
      $display("FAIL sat_stats got done=%b sum=%0d err=%0d max=%0d exp 1 131071 4 65025",
               s4_done, s4_sum, s4_err, s4_max);
    end
  endtask

  task automatic test_reset_mid_run;
    st_big = 1'b1;
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    st_big = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'd3, 8'd3, 17'd10);
    checks++;
    if (big_cnt !== 17'd10 || big_busy !== 1'b1 || big_err !== 17'd9) begin
      failures++;
      $display("FAIL mid_progress got cnt=%0d busy=%b err=%0d exp 10 1 9", big_cnt, big_busy, big_err);
    end
    rst = 1'b1;
    cyc(1'b1, 8'd3, 8'd3, 17'd10);
    rst = 1'b0;
    checks++;
    if ({big_rdy, big_busy, big_done, big_cnt, big_err, big_sum, big_max, big_m1, big_m2} !== '0) begin
      failures++;
      $display("FAIL mid_reset got rdy=%b busy=%b done=%b cnt=%0d err=%0d sum=%0d max=%0d exp all 0",
               big_rdy, big_busy, big_done, big_cnt, big_err, big_sum, big_max);
    end
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    checks++;
    if (big_cnt !== 17'd0 || big_err !== 17'd0 || s2_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_flush got cnt=%0d err=%0d s2_done=%b exp 0 0 0", big_cnt, big_err, s2_done);
    end
    st2 = 1'b1;
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    st2 = 1'b0;
    cyc(1'b1, 8'd122, 8'd122, 17'd14884);
    cyc(1'b1, 8'd1, 8'd1, 17'd2);
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    checks++;
    if (s2_done !== 1'b1 || s2_cnt !== 17'd2 || s2_err !== 17'd1 || s2_sum !== 40'd1) begin
      failures++;
      $display("FAIL mid_rerun got done=%b cnt=%0d err=%0d sum=%0d exp 1 2 1 1",
               s2_done, s2_cnt, s2_err, s2_sum);
    end
    checks++;
    if (s2_max !== 17'd1 || s2_m1 !== 8'd1 || s2_m2 !== 8'd1) begin
      failures++;
      $display("FAIL mid_rerun_max got max=%0d in1=%0d in2=%0d exp 1 1 1", s2_max, s2_m1, s2_m2);
    end
  endtask

  task automatic test_exhaustive;
    st_big = 1'b1;
    cyc(1'b0, 8'd0, 8'd0, 17'd0);
    st_big = 1'b0;
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 256; b++)
        cyc(1'b1, 8'(a), 8'(b), 17'(a * b));
    checks++;
    if (big_cnt !== 17'd65536 || big_rdy !== 1'b0 || big_done !== 1'b0) begin
      failures++;
      $display("FAIL exh_last got cnt=%0d rdy=%b done=%b exp 65536 0 0", big_cnt, big_rdy, big_done);
    end
    cyc(1'b1, 8'd255, 8'd255, 17'd0);
    checks++;
    if (big_done !== 1'b0) begin
      failures++;
      $display("FAIL exh_early_done got done=%b exp 0", big_done);
    end
    cyc(1'b1, 8'd255, 8'd255, 17'd0);
    checks++;
    if (big_done !== 1'b1 || big_cnt !== 17'd65536 || big_err !== 17'd0 ||
        big_sum !== 40'd0 || big_max !== 17'd0) begin
      failures++;
      $display("FAIL exh_stats got done=%b cnt=%0d err=%0d sum=%0d max=%0d exp 1 65536 0 0 0",
               big_done, big_cnt, big_err, big_sum, big_max);
    end
  endtask

  initial begin
    rst = 1'b1;
    st_big = 1'b0;
    st3 = 1'b0;
    st2 = 1'b0;
    st4 = 1'b0;
    in_valid = 1'b0;
    in1 = '0;
    in2 = '0;
    approx_out = '0;
    test_reset();
    test_over_under();
    test_tie();
    test_bubbles();
    test_saturation();
    test_reset_mid_run();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
